// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic-light controller:
// state codes, lamp encodings and the per-state dwell lookup.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_MAIN_G  = 3'd0,
        S_MAIN_Y  = 3'd1,
        S_AR1     = 3'd2,
        S_SIDE_G  = 3'd3,
        S_SIDE_Y  = 3'd4,
        S_AR2     = 3'd5,
        S_FLASH   = 3'd6,
        S_ILLEGAL = 3'd7
    } state_e;

    // One-hot lamp codes, bit order {R,Y,G}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    // Dwell time in cycles for a state; in FLASH it is the blink half-period.
    // The illegal code gets a non-zero value so that dwell-1 never underflows.
    function automatic int unsigned dwell_for(
        input state_e      s,
        input int unsigned t_main_g,
        input int unsigned t_side_g,
        input int unsigned t_y,
        input int unsigned t_ar,
        input int unsigned t_flash
    );
        case (s)
            S_MAIN_G:           return t_main_g;
            S_MAIN_Y, S_SIDE_Y: return t_y;
            S_SIDE_G:           return t_side_g;
            S_FLASH:            return t_flash;
            default:            return t_ar;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: up-counter with synchronous clear that flags the last cycle
// of the current phase (count == limit-1).
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] limit_m1_i,
    output logic [CNT_W-1:0] count_o,
    output logic             terminal_o
);

    logic [CNT_W-1:0] count_q;

    // Count up each cycle; restart from zero whenever the phase changes or wraps.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
    // the async reset sits in the sensitivity list so it acts without a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o    = count_q;
    assign terminal_o = (count_q == limit_m1_i);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road Moore traffic-light controller with all-red clearance,
// a latched pedestrian request that can shorten main green, and a
// flashing night mode.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned T_MAIN_G = 20,
    parameter int unsigned T_MIN_G  = 6,
    parameter int unsigned T_SIDE_G = 12,
    parameter int unsigned T_Y      = 4,
    parameter int unsigned T_AR     = 2,
    parameter int unsigned T_FLASH  = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flash_mode,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic [2:0] state_o
);

    // Every dwell must be non-zero and its terminal count (T-1) must fit in CNT_W bits.
    localparam logic [63:0] T_CAP = 64'd1 << CNT_W;
    localparam bit PARAMS_OK =
        (T_MAIN_G != 0) && (64'(T_MAIN_G) <= T_CAP) &&
        (T_SIDE_G != 0) && (64'(T_SIDE_G) <= T_CAP) &&
        (T_Y      != 0) && (64'(T_Y)      <= T_CAP) &&
        (T_AR     != 0) && (64'(T_AR)     <= T_CAP) &&
        (T_FLASH  != 0) && (64'(T_FLASH)  <= T_CAP) &&
        (T_MIN_G  >= 1) && (T_MIN_G <= T_MAIN_G);

    if (!PARAMS_OK) begin : g_param_check
        $error("traffic_light_ctrl: dwell parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] MIN_G_M1 = CNT_W'(T_MIN_G - 1);

    state_e           state_q, state_d;
    logic             ped_q;
    logic             blink_q;
    logic [CNT_W-1:0] timer_w;
    logic [CNT_W-1:0] limit_m1;
    logic             terminal;
    logic             timer_clr;

    assign limit_m1 = CNT_W'(dwell_for(state_q, T_MAIN_G, T_SIDE_G, T_Y, T_AR, T_FLASH) - 32'd1);

    // The timer restarts on any state change and also wraps at the end of each flash half-period.
    assign timer_clr = (state_d != state_q) || terminal;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (timer_clr),
        .limit_m1_i (limit_m1),
        .count_o    (timer_w),
        .terminal_o (terminal)
    );

    // Next-state selection: flash request beats timer expiry, which beats pedestrian early exit.
    // NOTE: state_d gets a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (state_q == S_FLASH) begin
            if (!flash_mode) state_d = S_AR2;
        end else if (state_q == S_ILLEGAL) begin
            state_d = S_AR2;
        end else if (flash_mode) begin
            state_d = S_FLASH;
        end else if (terminal) begin
            case (state_q)
                S_MAIN_G: state_d = S_MAIN_Y;
                S_MAIN_Y: state_d = S_AR1;
                S_AR1:    state_d = S_SIDE_G;
                S_SIDE_G: state_d = S_SIDE_Y;
                S_SIDE_Y: state_d = S_AR2;
                S_AR2:    state_d = S_MAIN_G;
                default:  state_d = S_AR2;
            endcase
        end else if (state_q == S_MAIN_G && ped_q && timer_w >= MIN_G_M1) begin
            state_d = S_MAIN_Y;
        end
    end

    // State register, pedestrian latch and flash blink phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_MAIN_G;
            ped_q   <= 1'b0;
            blink_q <= 1'b1;
        end else begin
            state_q <= state_d;

            // Entering side green serves the request, so clearing wins over a same-edge set.
            if (state_d == S_SIDE_G && state_q != S_SIDE_G) begin
                ped_q <= 1'b0;
            end else if (ped_req && state_q != S_SIDE_G) begin
                ped_q <= 1'b1;
            end

            if (state_d == S_FLASH && state_q != S_FLASH) begin
                blink_q <= 1'b1;
            end else if (state_q == S_FLASH && state_d == S_FLASH && terminal) begin
                blink_q <= ~blink_q;
            end
        end
    end

    // Moore lamp decode from the state register; the illegal code shows all red.
    always_comb begin
        main_light = RED;
        side_light = RED;
        ped_walk   = 1'b0;
        case (state_q)
            S_MAIN_G: main_light = GRN;
            S_MAIN_Y: main_light = YEL;
            S_SIDE_G: begin
                side_light = GRN;
                ped_walk   = 1'b1;
            end
            S_SIDE_Y: side_light = YEL;
            S_FLASH: begin
                main_light = blink_q ? YEL : OFF;
                side_light = blink_q ? RED : OFF;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule
